// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event arbiter: FSM state encoding,
// debounce hold-off length and the round-robin search function.
package btn_evt_pkg;

  localparam int DEBOUNCE_CYCLES = 5;
  localparam int MAX_BTN         = 16;

  typedef enum logic {EMPTY, FULL} evt_state_t;

  // Returns {found, idx}: first set bit of pend searching ptr+1, ptr+2, ...
  // modulo n. Operates on the widest supported vector and the caller zero-pads.
  function automatic logic [4:0] rr_pick(input logic [MAX_BTN-1:0] pend,
                                         input logic [3:0]         ptr,
                                         input int                 n);
    logic       found;
    logic [3:0] idx;
    int         j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= MAX_BTN; k++) begin
      // ptr < n and k <= n, so a single subtraction is enough to wrap
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k <= n) && !found && pend[j[3:0]]) begin
        found = 1'b1;
        idx   = j[3:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button debouncer: any change of the raw level is passed straight to
// stable, after which the input is ignored for DEBOUNCE_CYCLES cycles.
module debounce
  import btn_evt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // A single high sample is accepted immediately, so even a one-cycle pulse
  // becomes one clean press; bounces inside the window are never seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (raw != stable) begin
      stable <= raw;
      cnt    <= CW'(DEBOUNCE_CYCLES - 1);
    end
  end

endmodule

// File: rtl/rr_arbiter_comb.sv
// Pure combinational round-robin pick: first requesting index after ptr,
// wrapping modulo N_BTN (which need not be a power of two).
module rr_arbiter_comb
  import btn_evt_pkg::*;
#(
  parameter  int N_BTN = 4,
  localparam int IDX_W = $clog2(N_BTN)
) (
  input  logic [N_BTN-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_BTN-1:0] req_w;
  logic [3:0]         ptr_w;
  logic [4:0]         res;

  always_comb begin
    req_w              = '0;
    req_w[N_BTN-1:0]   = req;
    ptr_w              = '0;
    ptr_w[IDX_W-1:0]   = ptr;
    res                = rr_pick(req_w, ptr_w, N_BTN);
    found              = res[4];
    idx                = IDX_W'(res[3:0]);
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N_BTN raw buttons, latches press edges as pending and serialises
// them round-robin onto a single valid/ready event port with overrun flags.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter  int N_BTN = 4,
  localparam int IDX_W = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun,
  input  logic [N_BTN-1:0] clr_overrun
);

  logic             db_rst;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pending_d;
  logic [N_BTN-1:0] overrun_d;
  logic [N_BTN-1:0] ovr_set;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             load;
  evt_state_t       state, state_d;

  assign db_rst = ~rst_n;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    debounce u_debounce (
      .clk    (clk),
      .rst    (db_rst),
      .raw    (btn_raw[g]),
      .stable (stable[g])
    );
  end

  // Stage: edge detect on the debounced level
  assign rise = stable & ~stable_q;

  rr_arbiter_comb #(.N_BTN(N_BTN)) u_rr (
    .req   (pending),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      EMPTY: begin
        if (pick_found) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // Accepting and reloading in one cycle keeps back-to-back throughput
        if (evt_ready) begin
          if (pick_found) load    = 1'b1;
          else            state_d = EMPTY;
        end
      end
    endcase
  end

  // Stage: pending/overrun bookkeeping; a new press always beats a grant clear
  always_comb begin
    grant = '0;
    if (load) grant = N_BTN'(1) << pick_idx;
    pending_d = rise | (pending & ~grant);
    ovr_set   = rise & pending & ~grant;
    overrun_d = ovr_set | (overrun & ~clr_overrun);
  end

  assign evt_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      stable_q <= '0;
      pending  <= '0;
      overrun  <= '0;
      evt_idx  <= '0;
      rr_ptr   <= IDX_W'(N_BTN - 1);
    end else begin
      state    <= state_d;
      stable_q <= stable;
      pending  <= pending_d;
      overrun  <= overrun_d;
      if (load) begin
        evt_idx <= pick_idx;
        rr_ptr  <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: press latency, bounce, round-robin
// order, backpressure/overrun and asynchronous reset.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic       evt_ready = 1'b1;
  logic [3:0] clr_overrun = '0;
  logic       evt_valid;
  logic [1:0] evt_idx;
  logic [3:0] pending;
  logic [3:0] overrun;

  int n_chk = 0;
  int n_err = 0;
  int ev_cnt = 0;
  int ev_log [256];
  int base;

  button_event_arbiter #(.N_BTN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_idx     (evt_idx),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge view is the handshake
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      ev_log[ev_cnt[7:0]] <= int'(evt_idx);
      ev_cnt <= ev_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_valid",   32'(evt_valid), 32'd0);
    check("rst_idx",     32'(evt_idx),   32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single press on button 2, ready held high
    base = ev_cnt;
    btn_raw = 4'b0100;
    cyc();
    check("sp_pend_E",    32'(pending),   32'd0);
    cyc();
    check("sp_pend_E1",   32'(pending),   32'b0100);
    check("sp_valid_E1",  32'(evt_valid), 32'd0);
    cyc();
    check("sp_valid_E2",  32'(evt_valid), 32'd1);
    check("sp_idx_E2",    32'(evt_idx),   32'd2);
    check("sp_pend_E2",   32'(pending),   32'd0);
    cyc();
    check("sp_valid_E3",  32'(evt_valid), 32'd0);
    cyc(10);
    check("sp_count",     32'(ev_cnt - base), 32'd1);
    check("sp_logidx",    32'(ev_log[base]),  32'd2);
    btn_raw = '0;
    cyc(10);
    check("sp_release",   32'(ev_cnt - base), 32'd1);

    // Bounce train on button 1
    base = ev_cnt;
    btn_raw[1] = 1'b1; cyc();
    btn_raw[1] = 1'b0; cyc();
    btn_raw[1] = 1'b1; cyc();
    btn_raw[1] = 1'b0; cyc();
    btn_raw[1] = 1'b1;
    cyc(12);
    check("bn_count",   32'(ev_cnt - base), 32'd1);
    check("bn_idx",     32'(ev_log[base]),  32'd1);
    check("bn_overrun", 32'(overrun),       32'd0);
    btn_raw = '0;
    cyc(12);

    // Simultaneous presses from reset pointer (rr_ptr = 3)
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    base = ev_cnt;
    btn_raw = 4'b1011;
    cyc(2);
    check("sim_pend",   32'(pending),   32'b1011);
    cyc();
    check("sim_v0",     32'(evt_valid), 32'd1);
    check("sim_i0",     32'(evt_idx),   32'd0);
    check("sim_p0",     32'(pending),   32'b1010);
    cyc();
    check("sim_i1",     32'(evt_idx),   32'd1);
    check("sim_p1",     32'(pending),   32'b1000);
    cyc();
    check("sim_i3",     32'(evt_idx),   32'd3);
    check("sim_p3",     32'(pending),   32'd0);
    cyc();
    check("sim_vend",   32'(evt_valid), 32'd0);
    check("sim_count",  32'(ev_cnt - base), 32'd3);
    btn_raw = '0;
    cyc(12);
    // Move rr_ptr to 1, then re-press 1 and 3: 3 must win
    btn_raw = 4'b0010;
    cyc(6);
    btn_raw = '0;
    cyc(12);
    btn_raw = 4'b1010;
    cyc(3);
    check("rr2_first",  32'(evt_idx),   32'd3);
    cyc();
    check("rr2_second", 32'(evt_idx),   32'd1);
    btn_raw = '0;
    cyc(12);

    // Backpressure and overrun on button 0
    evt_ready = 1'b0;
    btn_raw = 4'b0001;
    cyc(3);
    check("bp_valid",   32'(evt_valid), 32'd1);
    check("bp_idx",     32'(evt_idx),   32'd0);
    cyc(8);
    check("bp_hold",    32'(evt_valid), 32'd1);
    btn_raw = '0;
    cyc(12);
    btn_raw = 4'b0001;
    cyc(2);
    check("bp_pend2",   32'(pending),   32'b0001);
    check("bp_ovr2",    32'(overrun),   32'd0);
    check("bp_idx2",    32'(evt_idx),   32'd0);
    btn_raw = '0;
    cyc(12);
    btn_raw = 4'b0001;
    cyc(2);
    check("bp_ovr3",    32'(overrun),   32'b0001);
    check("bp_pend3",   32'(pending),   32'b0001);
    base = ev_cnt;
    evt_ready = 1'b1;
    cyc();
    check("bp_reload",  32'(evt_valid), 32'd1);
    check("bp_rl_pend", 32'(pending),   32'd0);
    cyc();
    check("bp_empty",   32'(evt_valid), 32'd0);
    check("bp_count",   32'(ev_cnt - base), 32'd2);
    check("bp_log1",    32'(ev_log[base + 1]), 32'd0);
    check("bp_ovr_stk", 32'(overrun),   32'b0001);
    clr_overrun = 4'b0001;
    cyc();
    clr_overrun = '0;
    check("bp_ovr_clr", 32'(overrun),   32'd0);
    btn_raw = '0;
    cyc(12);

    // Asynchronous reset while FULL with idx=2, pending=1010
    evt_ready = 1'b0;
    btn_raw = 4'b0100;
    cyc(3);
    btn_raw = 4'b1110;
    cyc(2);
    btn_raw = 4'b1100;
    cyc(12);
    btn_raw = 4'b1110;
    cyc(2);
    check("ar_valid_pre", 32'(evt_valid), 32'd1);
    check("ar_idx_pre",   32'(evt_idx),   32'd2);
    check("ar_pend_pre",  32'(pending),   32'b1010);
    check("ar_ovr_pre",   32'(overrun),   32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",   32'(evt_valid), 32'd0);
    check("ar_pending", 32'(pending),   32'd0);
    check("ar_overrun", 32'(overrun),   32'd0);
    btn_raw = '0;
    evt_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    base = ev_cnt;
    cyc(15);
    check("ar_noevt",   32'(ev_cnt - base), 32'd0);
    check("ar_idle",    32'(evt_valid), 32'd0);
    check("ar_pend_end", 32'(pending),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Turns N raw push-button inputs into a single stream of press events for the user-logic FSMs, for example SPI command triggers.
- Each input runs through the existing `debounce` block. A rising edge of the stable signal marks that button pending.
- Pending buttons are granted round-robin onto one valid/ready event port.
- Presses that arrive while the same button is still pending are flagged as overruns.

Parameters:
- N_BTN, 4, number of button inputs (2..16).
- IDX_W, $clog2(N_BTN), width of the event index (derived; not overridden).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  unsynchronised button levels, active-high.
- evt_valid  out  1  event held on evt_idx.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at posedge.
- evt_idx  out  IDX_W  index of the pressed button.
- pending  out  N_BTN  per-button pending flags (status).
- overrun  out  N_BTN  sticky per-button lost-press flags.
- clr_overrun  in  N_BTN  write-1-to-clear for overrun, one cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - evt_valid=0, evt_idx=0, pending=0, overrun=0.
  - stable_q=0 and rr_ptr=N_BTN-1, so the first search starts at index 0.
  - Debounce instances are driven with rst = ~rst_n. Their counters clear on the next clk edge while reset is held.
- Per button i:
  - stable[i] comes from debounce (5-cycle hold-off).
  - stable_q[i] is stable[i] registered.
  - rise[i] = stable[i] & ~stable_q[i].
- Pending update, each posedge:
  - pending[i] is set if rise[i].
  - pending[i] is cleared if i is granted this cycle.
  - If set and clear coincide, set wins; no press is lost.
  - If rise[i] && pending[i] && !(granted i this cycle), then overrun[i] <= 1 and pending stays 1 (events coalesce).
  - clr_overrun[i] clears overrun[i]. If clear and a new overrun coincide, set wins.
- Output FSM, two states:
  - EMPTY (evt_valid=0): if any pending, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_BTN. Load evt_idx, set rr_ptr to the granted index, go to FULL.
  - FULL (evt_valid=1): evt_idx is stable until the handshake. On evt_valid && evt_ready:
    - if another pending bit exists, grant it in the same cycle (round-robin from the updated pointer) and stay FULL, giving back-to-back throughput of one event per cycle;
    - otherwise go to EMPTY.
  - The granted pending bit clears when the button is loaded into the output register, not when the event is accepted.
- Latency:
  - Let edge E be the first posedge that samples btn_raw[i]=1.
  - stable rises after E, pending[i] after E+1, evt_valid after E+2, provided the FSM is EMPTY and no other button is pending.
- Bounce:
  - Any high sample starts a debounce window, so even a 1-cycle pulse yields one event.
  - Toggling within the window yields exactly one event.
- Wrap: rr_ptr wraps from N_BTN-1 to 0. Index arithmetic is modulo N_BTN, which need not be a power of two.
- evt_ready while EMPTY is ignored.
- Reset mid-FSULL: the held event is dropped and all flags clear.

Decomposition:
- Package btn_evt_pkg:
  - DEBOUNCE_CYCLES=5, matching the debounce block;
  - typedef enum logic {EMPTY, FULL} evt_state_t;
  - function rr_pick(pending, ptr) returning {found, idx}.
- Sub-modules:
  - `debounce` reused via generate, N_BTN instances;
  - one new sub-module, rr_arbiter_comb: pure round-robin priority pick, parameterised by N_BTN.

Test Plan:
- Single press:
  - Stimulus: btn_raw[2] goes high at edge 10 and holds; evt_ready=1.
  - Required: evt_valid high for exactly one cycle after edge 12 with evt_idx=2; pending[2] high for one cycle; no further events while held.
- Bounce train:
  - Stimulus: btn_raw[1] toggles 1,0,1,0,1 on consecutive cycles, then stays 1.
  - Required: exactly one event, idx=1; overrun=0.
- Simultaneous presses:
  - Stimulus: buttons 0, 1 and 3 rise on the same edge; evt_ready=1; reset state rr_ptr=3.
  - Required: events 0, 1, 3 on consecutive cycles. A second round of 1 and 3 after release/re-press grants 3 first (rr_ptr=1).
- Backpressure and overrun:
  - Stimulus: evt_ready=0; press button 0, release after 8 cycles, press again.
  - Required: evt_valid held with idx=0; pending[0]=1 after the second press.
  - Then press a third time while pending → overrun[0]=1.
  - Then evt_ready=1 → exactly one more event, idx=0.
  - Then pulse clr_overrun[0] → overrun[0]=0.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously while FULL with idx=2 and pending=4'b1010.
  - Required: evt_valid, pending and overrun are 0 immediately, without waiting for a clock edge. After release with buttons low, no events.
